// File: rtl/hexdisp_pkg.sv
// Shared constants and the hex-to-7-segment decode for the multiplexed hex display.
// Segment order is {g,f,e,d,c,b,a}, active high here; the top inverts for the pins.
package hexdisp_pkg;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam int         BRIGHT_W = 4;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hexdisp_tick.sv
// Modulo-N counter producing a one-cycle wrap pulse while the count sits at N-1.
module hexdisp_tick #(
    parameter int N = 12000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic wrap
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wrap = (cnt_q == LAST);

endmodule

// File: rtl/hex_display_mux.sv
// Time-multiplexed common-anode hex display driver with shadow loading, PWM brightness
// and a timebase tick. Define HEXDISP_LZS_EN to enable leading-zero suppression.
module hex_display_mux
    import hexdisp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_LOG2 = 12,
    parameter int TICK_DIV     = 12000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [3:0]              bright_in,
    input  logic                    load,
    output logic                    pending,
    output logic                    frame_done,
    output logic [6:0]              SEG,
    output logic                    DP,
    output logic [NUM_DIGITS-1:0]   COMM,
    output logic                    sec_tick,
    output logic                    sec_toggle
);

    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DW-1:0] LAST_DIG = DW'(NUM_DIGITS - 1);

    logic [REFRESH_LOG2-1:0] slot_q, slot_d;
    logic [DW-1:0]           dig_q, dig_d;
    logic [4*NUM_DIGITS-1:0] act_hex_q, act_hex_d, sh_hex_q, sh_hex_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d, sh_blank_q, sh_blank_d;
    logic [BRIGHT_W-1:0]     act_bright_q, act_bright_d, sh_bright_q, sh_bright_d;
    logic                    pending_q, pending_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   comm_q, comm_d;
    logic                    toggle_q, toggle_d;
    logic                    tick_wrap;
    logic                    frame_end;
    logic                    lzs_dark;
    logic                    lit;
    logic [3:0]              cur_nib;

    hexdisp_tick #(.N(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .wrap  (tick_wrap)
    );

    assign frame_end = (slot_q == '1) && (dig_q == LAST_DIG);

    // Slot/digit sequencing and the shadow-to-active handoff at the frame boundary.
    always_comb begin
        slot_d       = slot_q + REFRESH_LOG2'(1);
        dig_d        = dig_q;
        sh_hex_d     = sh_hex_q;
        sh_dp_d      = sh_dp_q;
        sh_blank_d   = sh_blank_q;
        sh_bright_d  = sh_bright_q;
        act_hex_d    = act_hex_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        act_bright_d = act_bright_q;
        pending_d    = pending_q;
        toggle_d     = toggle_q ^ tick_wrap;

        if (slot_q == '1) begin
            dig_d = (dig_q == LAST_DIG) ? '0 : dig_q + DW'(1);
        end

        if (load) begin
            sh_hex_d    = hex_in;
            sh_dp_d     = dp_in;
            sh_blank_d  = blank_in;
            sh_bright_d = bright_in;
        end

        if (frame_end) begin
            pending_d = 1'b0;
            if (load) begin
                act_hex_d    = hex_in;
                act_dp_d     = dp_in;
                act_blank_d  = blank_in;
                act_bright_d = bright_in;
            end else if (pending_q) begin
                act_hex_d    = sh_hex_q;
                act_dp_d     = sh_dp_q;
                act_blank_d  = sh_blank_q;
                act_bright_d = sh_bright_q;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        cur_nib  = act_hex_q[{dig_q, 2'b00} +: 4];
        lzs_dark = 1'b0;
`ifdef HEXDISP_LZS_EN
        // A digit above 0 goes dark only when it and every nibble above it are zero.
        lzs_dark = (dig_q != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(dig_q) && act_hex_q[k*4 +: 4] != 4'h0) begin
                lzs_dark = 1'b0;
            end
        end
`endif
        lit = !act_blank_q[dig_q] && !lzs_dark
              && (slot_q[REFRESH_LOG2-1 -: BRIGHT_W] <= act_bright_q);

        seg_d  = SEG_OFF;
        dp_d   = 1'b1;
        comm_d = '1;
        if (lit) begin
            seg_d  = ~hex_to_seg(cur_nib);
            dp_d   = ~act_dp_q[dig_q];
            comm_d = ~(NUM_DIGITS'(1) << dig_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q       <= '0;
            dig_q        <= '0;
            act_hex_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            act_bright_q <= 4'hF;
            sh_hex_q     <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '0;
            sh_bright_q  <= 4'hF;
            pending_q    <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            comm_q       <= '1;
            toggle_q     <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            dig_q        <= dig_d;
            act_hex_q    <= act_hex_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            act_bright_q <= act_bright_d;
            sh_hex_q     <= sh_hex_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            sh_bright_q  <= sh_bright_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            comm_q       <= comm_d;
            toggle_q     <= toggle_d;
        end
    end

    assign pending    = pending_q;
    assign frame_done = frame_end;
    assign SEG        = seg_q;
    assign DP         = dp_q;
    assign COMM       = comm_q;
    assign sec_tick   = tick_wrap;
    assign sec_toggle = toggle_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Directed bench for hex_display_mux: 4 digits, 16-clock slots, 5-clock timebase.
// Output sampled at negedge n reflects the slot/digit state reached at posedge n-1.
module tb_hex_display_mux;

    localparam int ND = 4;
    localparam int RL = 4;
    localparam int TD = 5;
`ifdef HEXDISP_LZS_EN
    localparam logic [3:0] MASK_ZERO = 4'b0001;
    localparam logic [3:0] MASK_0005 = 4'b0001;
    localparam logic [3:0] MASK_0030 = 4'b0011;
`else
    localparam logic [3:0] MASK_ZERO = 4'b1111;
    localparam logic [3:0] MASK_0005 = 4'b1111;
    localparam logic [3:0] MASK_0030 = 4'b1111;
`endif

    logic          clk;
    logic          rst_n;
    logic [15:0]   hex_in;
    logic [3:0]    dp_in;
    logic [3:0]    blank_in;
    logic [3:0]    bright_in;
    logic          load;
    logic          pending;
    logic          frame_done;
    logic [6:0]    SEG;
    logic          DP;
    logic [3:0]    COMM;
    logic          sec_tick;
    logic          sec_toggle;

    int total;
    int bad;
    int cyc;
    logic [6:0] exp_q[$];

    hex_display_mux #(
        .NUM_DIGITS   (ND),
        .REFRESH_LOG2 (RL),
        .TICK_DIV     (TD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .bright_in  (bright_in),
        .load       (load),
        .pending    (pending),
        .frame_done (frame_done),
        .SEG        (SEG),
        .DP         (DP),
        .COMM       (COMM),
        .sec_tick   (sec_tick),
        .sec_toggle (sec_toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    function automatic logic [3:0] comm_for(input int d, input logic on);
        logic [3:0] c;
        c = 4'hF;
        if (on) c[d] = 1'b0;
        return c;
    endfunction

    initial begin
        int d;
        int s;
        logic on;
        logic [6:0] cur_seg;
        int low_cnt[4];

        total = 0; bad = 0; cyc = 0;
        rst_n = 1'b0; hex_in = '0; dp_in = '0; blank_in = '0; bright_in = 4'hF; load = 1'b0;
        cur_seg = 7'h40;
        repeat (3) @(negedge clk);

        chk("rst_seg", 16'(SEG), 16'h7F);
        chk("rst_dp", 16'(DP), 16'h1);
        chk("rst_comm", 16'(COMM), 16'hF);
        chk("rst_pending", 16'(pending), 16'h0);
        chk("rst_frame_done", 16'(frame_done), 16'h0);
        chk("rst_sec_tick", 16'(sec_tick), 16'h0);
        chk("rst_sec_toggle", 16'(sec_toggle), 16'h0);

        // Idle frame: digits scan 0..3, all showing 0; timebase runs alongside.
        rst_n = 1'b1;
        cyc = 0;
        for (int j = 1; j <= 64; j++) begin
            step();
            s  = cyc - 1;
            d  = (s / 16) % 4;
            on = MASK_ZERO[d];
            chk("idle_comm", 16'(COMM), 16'(comm_for(d, on)));
            chk("idle_seg", 16'(SEG), on ? 16'h40 : 16'h7F);
            chk("idle_dp", 16'(DP), 16'h1);
            chk("idle_frame_done", 16'(frame_done), (cyc % 64 == 63) ? 16'h1 : 16'h0);
            chk("idle_sec_tick", 16'(sec_tick), (cyc % 5 == 4) ? 16'h1 : 16'h0);
            chk("idle_sec_toggle", 16'(sec_toggle), 16'((cyc / 5) % 2));
        end

        // Mid-frame load of 12AF: old value stays until the frame boundary.
        while (cyc < 70) step();
        hex_in = 16'h12AF; load = 1'b1;
        step();
        load = 1'b0; hex_in = 16'h0000;
        exp_q.push_back(7'h0E);
        exp_q.push_back(7'h08);
        exp_q.push_back(7'h24);
        exp_q.push_back(7'h79);
        while (cyc <= 144) begin
            s = cyc - 1;
            d = (s / 16) % 4;
            chk("load_pending", 16'(pending), (cyc >= 71 && cyc <= 127) ? 16'h1 : 16'h0);
            if (cyc <= 128) begin
                on = MASK_ZERO[d];
                chk("load_old_seg", 16'(SEG), on ? 16'h40 : 16'h7F);
                chk("load_old_comm", 16'(COMM), 16'(comm_for(d, on)));
            end else begin
                if (s % 16 == 0 && exp_q.size() > 0) cur_seg = exp_q.pop_front();
                chk("load_new_seg", 16'(SEG), 16'(cur_seg));
                chk("load_new_comm", 16'(COMM), 16'(comm_for(d, 1'b1)));
            end
            step();
        end

        // Load coincident with frame_done goes straight to active, pending stays low.
        while (cyc < 191) step();
        chk("coin_frame_done", 16'(frame_done), 16'h1);
        chk("coin_pending_before", 16'(pending), 16'h0);
        hex_in = 16'h0005; load = 1'b1;
        step();
        load = 1'b0; hex_in = 16'h0000;
        while (cyc <= 224) begin
            s = cyc - 1;
            d = (s / 16) % 4;
            chk("coin_pending", 16'(pending), 16'h0);
            if (cyc >= 193 && cyc <= 208) begin
                chk("coin_d0_seg", 16'(SEG), 16'h12);
                chk("coin_d0_comm", 16'(COMM), 16'hE);
            end else if (cyc >= 209) begin
                on = MASK_0005[d];
                chk("coin_d1_comm", 16'(COMM), 16'(comm_for(d, on)));
            end
            step();
        end

        // Brightness 3 with digit 2 blanked and a decimal point on digit 1.
        while (cyc < 260) step();
        hex_in = 16'h0030; dp_in = 4'b0010; blank_in = 4'b0100; bright_in = 4'd3; load = 1'b1;
        step();
        load = 1'b0;
        chk("bright_pending", 16'(pending), 16'h1);
        while (cyc < 320) step();
        chk("bright_pending_clear", 16'(pending), 16'h0);
        for (int k = 0; k < 4; k++) low_cnt[k] = 0;
        for (int j = 321; j <= 384; j++) begin
            step();
            s  = cyc - 1;
            d  = (s / 16) % 4;
            on = MASK_0030[d] && (d != 2) && ((s % 16) <= 3);
            if (COMM[d] === 1'b0) low_cnt[d]++;
            chk("bright_comm", 16'(COMM), 16'(comm_for(d, on)));
            chk("bright_seg", 16'(SEG), !on ? 16'h7F : (d == 1) ? 16'h30 : 16'h40);
            chk("bright_dp", 16'(DP), (on && d == 1) ? 16'h0 : 16'h1);
        end
        chk("bright_lowcnt_d0", 16'(low_cnt[0]), 16'd4);
        chk("bright_lowcnt_d1", 16'(low_cnt[1]), 16'd4);
        chk("bright_lowcnt_d2", 16'(low_cnt[2]), 16'd0);
        chk("bright_lowcnt_d3", 16'(low_cnt[3]), MASK_0030[3] ? 16'd4 : 16'd0);

        // Asynchronous reset mid-slot drops pending shadow data.
        hex_in = 16'hFFFF; dp_in = 4'hF; blank_in = 4'h0; bright_in = 4'hF; load = 1'b1;
        step();
        load = 1'b0;
        chk("arst_pending_pre", 16'(pending), 16'h1);
        chk("arst_comm_pre", 16'(COMM), 16'hE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_comm", 16'(COMM), 16'hF);
        chk("arst_seg", 16'(SEG), 16'h7F);
        chk("arst_dp", 16'(DP), 16'h1);
        chk("arst_pending", 16'(pending), 16'h0);
        chk("arst_sec_toggle", 16'(sec_toggle), 16'h0);
        @(negedge clk);
        hex_in = 16'h0000; dp_in = 4'h0;
        rst_n = 1'b1;
        cyc = 0;
        step();
        chk("post_rst_comm", 16'(COMM), 16'hE);
        chk("post_rst_seg", 16'(SEG), 16'h40);
        chk("post_rst_dp", 16'(DP), 16'h1);
        while (cyc < 4) step();
        chk("post_rst_tick", 16'(sec_tick), 16'h1);
        while (cyc < 65) step();
        chk("post_rst_frame2_seg", 16'(SEG), 16'h40);
        chk("post_rst_frame2_pending", 16'(pending), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
